// File: rtl/dds_update_sequencer.sv
// Fans one decoded command packet out to NUM_CH DDS controllers. Each channel is
// handshaked individually with busy/finish timeouts, and TV/TH polarisation is sequenced from a trigger.
module dds_update_sequencer #(
    parameter int NUM_CH         = 2,
    parameter int BUSY_TIMEOUT   = 1024,
    parameter int FINISH_TIMEOUT = 65536,
    parameter int TMR_W          = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_ready,
    input  logic              pkt_crc_err,
    output logic              pkt_load,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] update,
    input  logic [NUM_CH-1:0] busy,
    input  logic [NUM_CH-1:0] finish,
    input  logic              trig,
    input  logic [1:0]        mode,
    output logic              tv,
    output logic              th,
    output logic              seq_busy,
    output logic              err_timeout,
    output logic [NUM_CH-1:0] err_ch,
    output logic [15:0]       done_cnt
);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_BUSY, WAIT_FINISH, LOAD, WAIT_RELEASE
    } state_t;

    localparam logic [TMR_W-1:0] BUSY_LAST   = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] FINISH_LAST = TMR_W'(FINISH_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] mask, mask_nxt;
    logic [NUM_CH-1:0] busy_seen, busy_seen_nxt;
    logic [NUM_CH-1:0] finish_seen, finish_seen_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic              abort, abort_nxt;
    logic [NUM_CH-1:0] update_nxt;
    logic              pkt_load_nxt;
    logic              err_timeout_nxt;
    logic [NUM_CH-1:0] err_ch_nxt;
    logic [15:0]       done_cnt_nxt;
    logic [NUM_CH-1:0] busy_m, finish_m;

    assign busy_m   = busy & mask;
    assign finish_m = finish & mask;
    assign seq_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mask        <= '0;
            busy_seen   <= '0;
            finish_seen <= '0;
            timer       <= '0;
            abort       <= 1'b0;
            update      <= '0;
            pkt_load    <= 1'b0;
            err_timeout <= 1'b0;
            err_ch      <= '0;
            done_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            mask        <= mask_nxt;
            busy_seen   <= busy_seen_nxt;
            finish_seen <= finish_seen_nxt;
            timer       <= timer_nxt;
            abort       <= abort_nxt;
            update      <= update_nxt;
            pkt_load    <= pkt_load_nxt;
            err_timeout <= err_timeout_nxt;
            err_ch      <= err_ch_nxt;
            done_cnt    <= done_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        mask_nxt        = mask;
        busy_seen_nxt   = busy_seen;
        finish_seen_nxt = finish_seen;
        timer_nxt       = timer;
        abort_nxt       = abort;
        update_nxt      = '0;
        pkt_load_nxt    = pkt_load;
        err_timeout_nxt = err_timeout;
        err_ch_nxt      = err_ch;
        done_cnt_nxt    = done_cnt;

        case (state)
            IDLE: begin
                if (pkt_ready) begin
                    mask_nxt        = ch_en;
                    busy_seen_nxt   = '0;
                    finish_seen_nxt = '0;
                    timer_nxt       = '0;
                    abort_nxt       = pkt_crc_err;
                    err_timeout_nxt = 1'b0;
                    err_ch_nxt      = '0;
                    state_nxt       = (pkt_crc_err || ch_en == '0) ? LOAD : START;
                end
            end
            START: begin
                update_nxt = mask;
                timer_nxt  = '0;
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                busy_seen_nxt   = busy_seen | busy_m;
                finish_seen_nxt = finish_seen | finish_m;
                // Each channel stops requesting as soon as its own busy is seen.
                update_nxt      = update & ~busy_m;
                timer_nxt       = timer + TMR_W'(1);
                if ((busy_seen | busy_m) == mask) begin
                    timer_nxt = '0;
                    state_nxt = WAIT_FINISH;
                end else if (timer == BUSY_LAST) begin
                    update_nxt      = '0;
                    err_timeout_nxt = 1'b1;
                    err_ch_nxt      = mask & ~(busy_seen | busy);
                    abort_nxt       = 1'b1;
                    state_nxt       = LOAD;
                end
            end
            WAIT_FINISH: begin
                finish_seen_nxt = finish_seen | finish_m;
                timer_nxt       = timer + TMR_W'(1);
                if ((finish_seen | finish_m) == mask) begin
                    state_nxt = LOAD;
                end else if (timer == FINISH_LAST) begin
                    err_timeout_nxt = 1'b1;
                    err_ch_nxt      = mask & ~(finish_seen | finish);
                    abort_nxt       = 1'b1;
                    state_nxt       = LOAD;
                end
            end
            LOAD: begin
                pkt_load_nxt = 1'b1;
                state_nxt    = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!pkt_ready) begin
                    pkt_load_nxt = 1'b0;
                    if (!abort)
                        done_cnt_nxt = done_cnt + 16'd1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Trigger crosses into clk through two flops; a third flop gives the rising edge.
    logic trig_meta, trig_sync, trig_prev, trig_rise;

    assign trig_rise = trig_sync & ~trig_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_meta <= 1'b0;
            trig_sync <= 1'b0;
            trig_prev <= 1'b0;
            tv        <= 1'b1;
            th        <= 1'b0;
        end else begin
            trig_meta <= trig;
            trig_sync <= trig_meta;
            trig_prev <= trig_sync;
            if (mode == 2'b11) begin
                if (trig_rise) begin
                    th <= tv;
                    tv <= ~tv;
                end
            end else if (mode == 2'b10) begin
                tv <= 1'b0;
                th <= 1'b1;
            end else begin
                tv <= 1'b1;
                th <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_update_sequencer.sv
// Directed bench for dds_update_sequencer: handshake, timeout, CRC skip,
// TV/TH sequencing and mid-operation reset, all against hand-computed values.
module tb_dds_update_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_ready, pkt_crc_err, pkt_load;
    logic [1:0]  ch_en, update, busy, finish, err_ch, mode;
    logic        trig, tv, th, seq_busy, err_timeout;
    logic [15:0] done_cnt;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    dds_update_sequencer #(
        .NUM_CH(2), .BUSY_TIMEOUT(16), .FINISH_TIMEOUT(64), .TMR_W(17)
    ) dut (
        .clk(clk), .rst(rst),
        .pkt_ready(pkt_ready), .pkt_crc_err(pkt_crc_err), .pkt_load(pkt_load),
        .ch_en(ch_en), .update(update), .busy(busy), .finish(finish),
        .trig(trig), .mode(mode), .tv(tv), .th(th),
        .seq_busy(seq_busy), .err_timeout(err_timeout), .err_ch(err_ch),
        .done_cnt(done_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic crc, input logic [1:0] en,
                                 input logic [1:0] bsy, input logic [1:0] fin);
        pkt_ready   = rdy;
        pkt_crc_err = crc;
        ch_en       = en;
        busy        = bsy;
        finish      = fin;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic trigPulse(input logic expTv, input logic expTh, input string tag);
        logic prevTv;
        prevTv = tv;
        trig = 1'b1;
        tick(2);
        checkOutput({tag, "_tv_hold"}, 32'(tv), 32'(prevTv));
        tick(1);
        checkOutput({tag, "_tv"}, 32'(tv), 32'(expTv));
        checkOutput({tag, "_th"}, 32'(th), 32'(expTh));
        trig = 1'b0;
        tick(3);
    endtask

    initial begin
        rst  = 1'b0;
        trig = 1'b0;
        mode = 2'b00;
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        tick(3);
        checkOutput("rst_pkt_load", 32'(pkt_load), 32'h0);
        checkOutput("rst_update", 32'(update), 32'h0);
        checkOutput("rst_seq_busy", 32'(seq_busy), 32'h0);
        checkOutput("rst_err_timeout", 32'(err_timeout), 32'h0);
        checkOutput("rst_err_ch", 32'(err_ch), 32'h0);
        checkOutput("rst_done_cnt", 32'(done_cnt), 32'h0);
        checkOutput("rst_tv", 32'(tv), 32'h1);
        checkOutput("rst_th", 32'(th), 32'h0);
        rst = 1'b1;
        tick(2);

        // Both channels, busy and finish together
        applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
        tick(1);
        checkOutput("t1_start_update", 32'(update), 32'h0);
        checkOutput("t1_seq_busy", 32'(seq_busy), 32'h1);
        tick(1);
        checkOutput("t1_update", 32'(update), 32'h3);
        tick(2);
        checkOutput("t1_update_hold", 32'(update), 32'h3);
        busy = 2'b11;
        tick(1);
        checkOutput("t1_update_drop", 32'(update), 32'h0);
        busy = 2'b00;
        tick(9);
        checkOutput("t1_no_load_early", 32'(pkt_load), 32'h0);
        finish = 2'b11;
        tick(1);
        checkOutput("t1_load_state", 32'(pkt_load), 32'h0);
        finish = 2'b00;
        tick(1);
        checkOutput("t1_pkt_load", 32'(pkt_load), 32'h1);
        pkt_ready = 1'b0;
        tick(1);
        checkOutput("t1_pkt_release", 32'(pkt_load), 32'h0);
        checkOutput("t1_done_cnt", 32'(done_cnt), 32'h1);
        checkOutput("t1_err_timeout", 32'(err_timeout), 32'h0);
        checkOutput("t1_idle", 32'(seq_busy), 32'h0);

        // Staggered busy responses
        applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
        tick(2);
        checkOutput("t2_update", 32'(update), 32'h3);
        tick(2);
        busy = 2'b01;
        tick(1);
        checkOutput("t2_update_ch0_drop", 32'(update), 32'h2);
        tick(2);
        checkOutput("t2_update_ch1_hold", 32'(update), 32'h2);
        busy = 2'b11;
        tick(1);
        checkOutput("t2_update_all_drop", 32'(update), 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 2'b11);
        tick(1);
        finish = 2'b00;
        tick(1);
        checkOutput("t2_pkt_load", 32'(pkt_load), 32'h1);
        pkt_ready = 1'b0;
        tick(1);
        checkOutput("t2_pkt_release", 32'(pkt_load), 32'h0);
        tick(1);
        checkOutput("t2_single_load", 32'(pkt_load), 32'h0);
        checkOutput("t2_done_cnt", 32'(done_cnt), 32'h2);

        // Busy timeout on channel 1; channel 0 is masked and its busy must be ignored
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b01, 2'b01);
        tick(2);
        checkOutput("t3_update", 32'(update), 32'h2);
        tick(15);
        checkOutput("t3_update_before_to", 32'(update), 32'h2);
        checkOutput("t3_no_err_yet", 32'(err_timeout), 32'h0);
        tick(1);
        checkOutput("t3_update_to", 32'(update), 32'h0);
        checkOutput("t3_err_timeout", 32'(err_timeout), 32'h1);
        checkOutput("t3_err_ch", 32'(err_ch), 32'h2);
        tick(1);
        checkOutput("t3_pkt_load", 32'(pkt_load), 32'h1);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        tick(1);
        checkOutput("t3_done_cnt", 32'(done_cnt), 32'h2);
        checkOutput("t3_err_hold", 32'(err_timeout), 32'h1);
        checkOutput("t3_err_ch_hold", 32'(err_ch), 32'h2);

        // CRC error: no update, quick release, error flags cleared on accept
        applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00);
        tick(1);
        checkOutput("t4_update", 32'(update), 32'h0);
        checkOutput("t4_err_clear", 32'(err_timeout), 32'h0);
        checkOutput("t4_err_ch_clear", 32'(err_ch), 32'h0);
        tick(1);
        checkOutput("t4_pkt_load", 32'(pkt_load), 32'h1);
        checkOutput("t4_update_still", 32'(update), 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        tick(1);
        checkOutput("t4_done_cnt", 32'(done_cnt), 32'h2);

        // Empty channel mask still completes as a clean packet
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        tick(2);
        checkOutput("t4b_pkt_load", 32'(pkt_load), 32'h1);
        pkt_ready = 1'b0;
        tick(1);
        checkOutput("t4b_done_cnt", 32'(done_cnt), 32'h3);

        // TV/TH toggling
        mode = 2'b11;
        tick(1);
        trigPulse(1'b0, 1'b1, "t5_p1");
        trigPulse(1'b1, 1'b0, "t5_p2");
        trigPulse(1'b0, 1'b1, "t5_p3");
        trigPulse(1'b1, 1'b0, "t5_p4");
        mode = 2'b10;
        tick(1);
        checkOutput("t5_fixed_tv", 32'(tv), 32'h0);
        checkOutput("t5_fixed_th", 32'(th), 32'h1);
        mode = 2'b11;
        tick(1);
        trigPulse(1'b1, 1'b0, "t5_reenter");
        mode = 2'b00;
        tick(1);
        checkOutput("t5_default_tv", 32'(tv), 32'h1);
        checkOutput("t5_default_th", 32'(th), 32'h0);

        // Reset in WAIT_FINISH, then rerun of the still-pending packet
        mode = 2'b10;
        applyStimulus(1'b1, 1'b0, 2'b11, 2'b11, 2'b00);
        tick(3);
        checkOutput("t6_tv_forced", 32'(tv), 32'h0);
        checkOutput("t6_in_wait_finish", 32'(seq_busy), 32'h1);
        tick(1);
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_update", 32'(update), 32'h0);
        checkOutput("t6_rst_pkt_load", 32'(pkt_load), 32'h0);
        checkOutput("t6_rst_tv", 32'(tv), 32'h1);
        checkOutput("t6_rst_seq_busy", 32'(seq_busy), 32'h0);
        checkOutput("t6_rst_done_cnt", 32'(done_cnt), 32'h0);
        tick(2);
        mode = 2'b00;
        busy = 2'b00;
        rst  = 1'b1;
        tick(1);
        checkOutput("t6_restart_busy", 32'(seq_busy), 32'h1);
        checkOutput("t6_restart_start", 32'(update), 32'h0);
        tick(1);
        checkOutput("t6_restart_update", 32'(update), 32'h3);
        busy = 2'b11;
        tick(1);
        applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 2'b11);
        tick(1);
        finish = 2'b00;
        tick(1);
        checkOutput("t6_pkt_load", 32'(pkt_load), 32'h1);
        pkt_ready = 1'b0;
        tick(1);
        checkOutput("t6_done_cnt", 32'(done_cnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
